// File: rtl/rc4_stream_core.sv
// RC4 / RC4-drop[n] stream cipher core: key schedule, optional keystream discard, then byte XOR.
// Latency: accepted byte appears registered on out_data the next cycle; key_ready 257+DROP_N edges after key_start sample.
// Backpressure: out_valid/out_data held until out_ready; in_ready drops while a held byte is not taken or during rekey.
module rc4_stream_core #(
    parameter int KEY_BYTES = 16,
    parameter int DROP_N    = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [8*KEY_BYTES-1:0]         key,
    input  logic [$clog2(KEY_BYTES+1)-1:0] key_len,
    input  logic                           key_start,
    output logic                           key_ready,
    output logic                           busy,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [7:0]                     out_data,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int         LEN_W     = $clog2(KEY_BYTES + 1);
    localparam logic [11:0] DROP_LAST = 12'((DROP_N > 0) ? (DROP_N - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_DROP,
        ST_RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [7:0]       s_box [256];
    logic [7:0]       i_q;
    logic [7:0]       j_q;
    logic [LEN_W-1:0] ki_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       key_q [KEY_BYTES];
    logic [11:0]      drop_cnt;

    logic [LEN_W-1:0] len_eff;
    logic [7:0]       key_byte;
    logic [7:0]       a_idx;
    logic [7:0]       b_idx;
    logic [7:0]       j_add;
    logic [7:0]       s_a;
    logic [7:0]       s_b;
    logic [7:0]       t_idx;
    logic [7:0]       ks;
    logic             accept;
    logic             step;

    // A zero or oversized key length means "use the whole key bus".
    assign len_eff = ((key_len == '0) || (key_len > LEN_W'(KEY_BYTES))) ? LEN_W'(KEY_BYTES) : key_len;

    // Select the latched key byte addressed by the key index.
    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (ki_q == LEN_W'(k)) begin
                key_byte = key_q[k];
            end
        end
    end

    // Shared swap datapath: KSA uses (i, j+S[i]+key), PRGA uses (i+1, j+S[i+1]);
    // the keystream byte is read as if the swap had already happened.
    always_comb begin
        a_idx = (state == ST_KSA) ? i_q : (i_q + 8'd1);
        j_add = (state == ST_KSA) ? key_byte : 8'd0;
        s_a   = s_box[a_idx];
        b_idx = j_q + s_a + j_add;
        s_b   = s_box[b_idx];
        t_idx = s_a + s_b;
        if (t_idx == a_idx) begin
            ks = s_b;
        end else if (t_idx == b_idx) begin
            ks = s_a;
        end else begin
            ks = s_box[t_idx];
        end
    end

    assign accept = in_valid & in_ready;
    assign step   = ~key_start & ((state == ST_KSA) | (state == ST_DROP) | accept);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; key_start restarts the schedule from any state.
    always_comb begin
        state_nxt = state;
        if (key_start) begin
            state_nxt = ST_INIT;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_INIT: state_nxt = ST_KSA;
                ST_KSA: begin
                    if (i_q == 8'hFF) begin
                        state_nxt = (DROP_N > 0) ? ST_DROP : ST_RUN;
                    end
                end
                ST_DROP: begin
                    if (drop_cnt == DROP_LAST) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN:  state_nxt = ST_RUN;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM-derived status and input handshake.
    always_comb begin
        key_ready = (state == ST_RUN);
        busy      = (state == ST_INIT) | (state == ST_KSA) | (state == ST_DROP);
        in_ready  = (state == ST_RUN) & ~key_start & (~out_valid | out_ready);
    end

    // Permutation table: identity fill in INIT, one swap per KSA/PRGA step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 256; n++) begin
                s_box[n] <= 8'h00;
            end
        end else if (!key_start) begin
            if (state == ST_INIT) begin
                for (int n = 0; n < 256; n++) begin
                    s_box[n] <= 8'(n);
                end
            end else if (step) begin
                s_box[a_idx] <= s_b;
                s_box[b_idx] <= s_a;
            end
        end
    end

    // Index registers i, j, key index and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q      <= 8'h00;
            j_q      <= 8'h00;
            ki_q     <= '0;
            drop_cnt <= 12'h000;
        end else if (!key_start) begin
            case (state)
                ST_INIT: begin
                    i_q      <= 8'h00;
                    j_q      <= 8'h00;
                    ki_q     <= '0;
                    drop_cnt <= 12'h000;
                end
                ST_KSA: begin
                    if (i_q == 8'hFF) begin
                        i_q <= 8'h00;
                        j_q <= 8'h00;
                    end else begin
                        i_q <= i_q + 8'd1;
                        j_q <= b_idx;
                    end
                    ki_q <= (ki_q == (len_q - LEN_W'(1))) ? '0 : (ki_q + LEN_W'(1));
                end
                ST_DROP: begin
                    i_q      <= a_idx;
                    j_q      <= b_idx;
                    drop_cnt <= drop_cnt + 12'd1;
                end
                ST_RUN: begin
                    if (accept) begin
                        i_q <= a_idx;
                        j_q <= b_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key and key length are captured only on key_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < KEY_BYTES; k++) begin
                key_q[k] <= 8'h00;
            end
            len_q <= '0;
        end else if (key_start) begin
            for (int k = 0; k < KEY_BYTES; k++) begin
                key_q[k] <= key[8*k +: 8];
            end
            len_q <= len_eff;
        end
    end

    // Output byte register; a rekey discards any byte still waiting for the sink.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (key_start) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ ks;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
